// File: rtl/msu_pkg.sv
// Shared types and sizing helpers for the msu result collector.
// Optional cycle counter in the top is enabled by MSU_COLLECT_CYCLE_COUNT_EN.
package msu_pkg;

    localparam int unsigned TotalWordBits    = 1024;
    localparam int unsigned DefaultChunkBits = 64;

    typedef logic [DefaultChunkBits-1:0] chunk_t;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StAdd,
        StOut
    } state_e;

    function automatic int unsigned num_chunks(input int unsigned data_bits,
                                               input int unsigned chunk_bits);
        return (data_bits + chunk_bits - 1) / chunk_bits;
    endfunction

endpackage

// File: rtl/msu_result_collector_if.sv
// Host / msu facing signal bundle of the result collector.
// cycle_count_o is present only with MSU_COLLECT_CYCLE_COUNT_EN.
interface msu_result_collector_if #(
    parameter int unsigned DataBits = msu_pkg::TotalWordBits,
    parameter int unsigned IterBits = 64
);
    logic [IterBits-1:0] cfg_iters_i;
    logic                go_i;
    logic                busy_o;
    logic                msu_start_o;
    logic                msu_stop_o;
    logic                msu_valid_i;
    logic [DataBits-1:0] msu_nr_i;
    logic [DataBits-1:0] msu_r_i;
    logic [IterBits-1:0] iter_count_o;
    logic [DataBits:0]   res_o;
    logic                res_valid_o;
    logic                res_ready_i;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
    logic [63:0]         cycle_count_o;
`endif

    modport slave (
        input  cfg_iters_i, go_i, msu_valid_i, msu_nr_i, msu_r_i, res_ready_i,
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
        output cycle_count_o,
`endif
        output busy_o, msu_start_o, msu_stop_o, iter_count_o, res_o, res_valid_o
    );

    modport master (
        output cfg_iters_i, go_i, msu_valid_i, msu_nr_i, msu_r_i, res_ready_i,
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
        input  cycle_count_o,
`endif
        input  busy_o, msu_start_o, msu_stop_o, iter_count_o, res_o, res_valid_o
    );

endinterface

// File: rtl/chunk_adder.sv
// One slice of the chunk-serial carry-propagate adder; the carry between
// slices lives in a register so successive cycles chain the chunks.
module chunk_adder #(
    parameter int unsigned ChunkBits = msu_pkg::DefaultChunkBits
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [ChunkBits-1:0] a_i,
    input  logic [ChunkBits-1:0] b_i,
    output logic [ChunkBits-1:0] sum_o,
    output logic                 carry_o
);
    logic carry_q;

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{ChunkBits{1'b0}}, carry_q};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            carry_q <= 1'b0;
        end else if (en_i) begin
            carry_q <= carry_o;
        end
    end

endmodule

// File: rtl/msu_result_collector.sv
// Launches msu for a programmed squaring count, captures the redundant result
// and sums it chunk-serially. MSU_COLLECT_CYCLE_COUNT_EN adds cycle_count_o.
module msu_result_collector
    import msu_pkg::*;
#(
    parameter int unsigned DataBits  = TotalWordBits,
    parameter int unsigned ChunkBits = DefaultChunkBits,
    parameter int unsigned IterBits  = 64
) (
    input logic                   clk_i,
    input logic                   rst_i,
    msu_result_collector_if.slave bus
);
    localparam int unsigned NumChunks = num_chunks(DataBits, ChunkBits);
    localparam int unsigned ExtBits   = NumChunks * ChunkBits;
    localparam int unsigned CntBits   = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    state_e              state_q;
    logic                busy_q, start_q, stop_q, res_valid_q;
    logic [IterBits-1:0] iters_q, iter_count_q;
    logic [ExtBits-1:0]  nr_q, r_q;
    logic [CntBits-1:0]  chunk_q;
    logic [DataBits:0]   res_q;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
    logic [63:0]         cycle_q;
`endif

    logic                 capture;
    logic [ExtBits-1:0]   nr_ext, r_ext, nr_shift;
    logic [ChunkBits-1:0] sum_chunk;
    logic                 carry_next;
    logic [ExtBits:0]     final_wide;

    assign capture = (state_q == StRun) && bus.msu_valid_i &&
                     (iter_count_q + IterBits'(1) == iters_q);

    always_comb begin
        nr_ext = '0;
        r_ext  = '0;
        nr_ext[DataBits-1:0] = bus.msu_nr_i;
        r_ext[DataBits-1:0]  = bus.msu_r_i;
    end

    chunk_adder #(
        .ChunkBits(ChunkBits)
    ) u_chunk_adder (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (capture),
        .en_i    (state_q == StAdd),
        .a_i     (nr_q[ChunkBits-1:0]),
        .b_i     (r_q[ChunkBits-1:0]),
        .sum_o   (sum_chunk),
        .carry_o (carry_next)
    );

    // The nr register doubles as the sum accumulator: sums enter at the top and
    // after NumChunks shifts chunk 0 sits at the bottom.
    always_comb begin
        nr_shift = nr_q >> ChunkBits;
        nr_shift[ExtBits-1 -: ChunkBits] = sum_chunk;
        // With zero padding the true carry already lands in bit DataBits of the sum.
        final_wide = {carry_next, nr_shift};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            iters_q      <= '0;
            iter_count_q <= '0;
            nr_q         <= '0;
            r_q          <= '0;
            chunk_q      <= '0;
            res_q        <= '0;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
            cycle_q      <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.go_i && (bus.cfg_iters_i != '0)) begin
                        state_q      <= StLaunch;
                        busy_q       <= 1'b1;
                        start_q      <= 1'b1;
                        iters_q      <= bus.cfg_iters_i;
                        iter_count_q <= '0;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
                        cycle_q      <= '0;
`endif
                    end
                end
                StLaunch: begin
                    state_q <= StRun;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
                    cycle_q <= cycle_q + 64'd1;
`endif
                end
                StRun: begin
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
                    cycle_q <= cycle_q + 64'd1;
`endif
                    if (bus.msu_valid_i && (iter_count_q < iters_q)) begin
                        iter_count_q <= iter_count_q + IterBits'(1);
                    end
                    if (capture) begin
                        nr_q    <= nr_ext;
                        r_q     <= r_ext;
                        stop_q  <= 1'b1;
                        chunk_q <= '0;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    nr_q    <= nr_shift;
                    r_q     <= r_q >> ChunkBits;
                    chunk_q <= chunk_q + CntBits'(1);
                    if (chunk_q == CntBits'(NumChunks - 1)) begin
                        res_q       <= final_wide[DataBits:0];
                        res_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.msu_start_o  = start_q;
    assign bus.msu_stop_o   = stop_q;
    assign bus.iter_count_o = iter_count_q;
    assign bus.res_o        = res_q;
    assign bus.res_valid_o  = res_valid_q;
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
    assign bus.cycle_count_o = cycle_q;
`endif

endmodule

// File: tb/tb_msu_result_collector.sv
// Self-checking bench for msu_result_collector: vector table, hand-written
// corner sequences and random jobs against a cycle-level msu/host model.
module tb_msu_result_collector;
    import msu_pkg::*;

    localparam int unsigned DataBits  = 1024;
    localparam int unsigned ChunkBits = 64;
    localparam int unsigned IterBits  = 64;
    localparam int          Lat       = (DataBits + ChunkBits - 1) / ChunkBits;

    typedef logic [DataBits-1:0] data_t;
    typedef logic [DataBits:0]   res_t;

    typedef struct {
        logic [IterBits-1:0] iters;
        int                  period;
        int                  hold;
        bit                  noise;
        data_t               nr;
        data_t               r;
        res_t                exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[4];

    msu_result_collector_if #(.DataBits(DataBits), .IterBits(IterBits)) bus ();

    msu_result_collector #(
        .DataBits (DataBits),
        .ChunkBits(ChunkBits),
        .IterBits (IterBits)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_res(input string name, input res_t act, input res_t exp);
        logic [32:0] at, et;
        logic [63:0] ab, eb;
        total++;
        if (act !== exp) begin
            bad++;
            at = act[DataBits -: 33];
            et = exp[DataBits -: 33];
            ab = act[63:0];
            eb = exp[63:0];
            $display("FAIL %s: got top=%h low=%h want top=%h low=%h at %0t",
                     name, at, ab, et, eb, $time);
        end
    endtask

    function automatic data_t rand_data();
        data_t d;
        for (int i = 0; i < DataBits / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic res_t model_sum(input data_t a, input data_t b);
        res_t wa, wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return wa + wb;
    endfunction

    task automatic chk_all_reset(input string tag);
        chk({tag, ".busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ".start"}, 64'(bus.msu_start_o), 64'd0);
        chk({tag, ".stop"}, 64'(bus.msu_stop_o), 64'd0);
        chk({tag, ".iter_count"}, bus.iter_count_o, 64'd0);
        chk({tag, ".res_valid"}, 64'(bus.res_valid_o), 64'd0);
        chk_res({tag, ".res"}, bus.res_o, '0);
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
        chk({tag, ".cycle_count"}, bus.cycle_count_o, 64'd0);
`endif
    endtask

    // Host + msu model: one full job from go to result handshake.
    task automatic run_job(input vec_t v, input string tag);
        int ncyc;
        bus.cfg_iters_i = v.iters;
        bus.go_i        = 1'b1;
        tick();
        bus.go_i        = 1'b0;
        bus.cfg_iters_i = 64'($urandom_range(1, 9));
        ncyc = 0;
        chk({tag, ".launch_start"}, 64'(bus.msu_start_o), 64'd1);
        chk({tag, ".launch_busy"}, 64'(bus.busy_o), 64'd1);
        tick();
        ncyc++;
        chk({tag, ".run_start"}, 64'(bus.msu_start_o), 64'd0);
        for (int vi = 1; vi <= int'(v.iters); vi++) begin
            for (int w = 0; w < v.period - 1; w++) begin
                bus.go_i = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                ncyc++;
                chk({tag, ".gap_start"}, 64'(bus.msu_start_o), 64'd0);
                chk({tag, ".gap_stop"}, 64'(bus.msu_stop_o), 64'd0);
            end
            bus.go_i        = 1'b0;
            bus.msu_valid_i = 1'b1;
            bus.msu_nr_i    = (vi == int'(v.iters)) ? v.nr : rand_data();
            bus.msu_r_i     = (vi == int'(v.iters)) ? v.r : rand_data();
            tick();
            ncyc++;
            bus.msu_valid_i = 1'b0;
            bus.msu_nr_i    = rand_data();
            bus.msu_r_i     = rand_data();
            chk({tag, ".iter_count"}, bus.iter_count_o, 64'(vi));
            if (vi < int'(v.iters)) chk({tag, ".early_stop"}, 64'(bus.msu_stop_o), 64'd0);
        end
        chk({tag, ".stop_pulse"}, 64'(bus.msu_stop_o), 64'd1);
        chk({tag, ".valid_early"}, 64'(bus.res_valid_o), 64'd0);
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
        chk({tag, ".cycle_count"}, bus.cycle_count_o, 64'(ncyc));
`endif
        for (int k = 1; k <= Lat; k++) begin
            bus.msu_valid_i = 1'($urandom_range(0, 1));
            bus.go_i        = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk({tag, ".stop_after"}, 64'(bus.msu_stop_o), 64'd0);
            chk({tag, ".res_valid_lat"}, 64'(bus.res_valid_o), (k == Lat) ? 64'd1 : 64'd0);
        end
        bus.msu_valid_i = 1'b0;
        bus.go_i        = 1'b0;
        chk({tag, ".iter_sat"}, bus.iter_count_o, v.iters);
        chk_res({tag, ".res"}, bus.res_o, v.exp_res);
`ifdef MSU_COLLECT_CYCLE_COUNT_EN
        chk({tag, ".cycle_hold"}, bus.cycle_count_o, 64'(ncyc));
`endif
        for (int h = 0; h < v.hold; h++) begin
            bus.res_ready_i = 1'b0;
            bus.go_i        = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk({tag, ".hold_valid"}, 64'(bus.res_valid_o), 64'd1);
            chk_res({tag, ".hold_res"}, bus.res_o, v.exp_res);
        end
        bus.res_ready_i = 1'b1;
        bus.go_i        = v.noise;
        tick();
        bus.res_ready_i = 1'b0;
        bus.go_i        = 1'b0;
        chk({tag, ".idle_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ".idle_valid"}, 64'(bus.res_valid_o), 64'd0);
        tick();
        chk({tag, ".no_relaunch"}, 64'(bus.msu_start_o), 64'd0);
        chk({tag, ".iter_kept"}, bus.iter_count_o, v.iters);
    endtask

    initial begin
        vec_t rv;
        data_t ones;
        ones = '1;
        vecs[0] = '{iters: 64'd3, period: 2, hold: 0, noise: 1'b0, nr: ones,
                    r: data_t'(1), exp_res: '0};
        vecs[1] = '{iters: 64'd5, period: 4, hold: 10, noise: 1'b1, nr: rand_data(),
                    r: rand_data(), exp_res: '0};
        vecs[2] = '{iters: 64'd1, period: 1, hold: 3, noise: 1'b0, nr: rand_data(),
                    r: rand_data(), exp_res: '0};
        vecs[3] = '{iters: 64'd2, period: 3, hold: 1, noise: 1'b1, nr: ones,
                    r: ones, exp_res: '0};
        foreach (vecs[i]) vecs[i].exp_res = model_sum(vecs[i].nr, vecs[i].r);

        bus.cfg_iters_i = '0;
        bus.go_i        = 1'b0;
        bus.msu_valid_i = 1'b0;
        bus.msu_nr_i    = '0;
        bus.msu_r_i     = '0;
        bus.res_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_all_reset("reset");
        rst = 1'b0;
        tick();

        // go with a zero count must not launch
        bus.cfg_iters_i = '0;
        bus.go_i        = 1'b1;
        tick();
        bus.go_i = 1'b0;
        chk("zero_go.start", 64'(bus.msu_start_o), 64'd0);
        chk("zero_go.busy", 64'(bus.busy_o), 64'd0);
        tick();
        chk("zero_go.start2", 64'(bus.msu_start_o), 64'd0);

        foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of the chunked add
        bus.cfg_iters_i = 64'd1;
        bus.go_i        = 1'b1;
        tick();
        bus.go_i = 1'b0;
        tick();
        bus.msu_valid_i = 1'b1;
        bus.msu_nr_i    = rand_data();
        bus.msu_r_i     = rand_data();
        tick();
        bus.msu_valid_i = 1'b0;
        tick();
        tick();
        chk("mid_add.busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        tick();
        chk_all_reset("mid_add_reset");
        rst = 1'b0;
        tick();
        run_job(vecs[0], "after_reset");

        for (int j = 0; j < 4; j++) begin
            rv.iters   = 64'($urandom_range(1, 6));
            rv.period  = $urandom_range(1, 4);
            rv.hold    = $urandom_range(0, 10);
            rv.noise   = 1'($urandom_range(0, 1));
            rv.nr      = rand_data();
            rv.r       = rand_data();
            rv.exp_res = model_sum(rv.nr, rv.r);
            run_job(rv, $sformatf("rand%0d", j));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msu_result_collector.md
# msu_result_collector

Sequencer and output stage directly downstream of the modular squaring unit `msu`. It launches `msu` for a programmed number of squarings and counts its `valid_o` pulses. On the final pulse it captures the redundant result pair (non-redundant + redundant vectors) and issues `stop`. It then collapses the pair into a single non-redundant value with a chunk-serial carry-propagate adder and presents the sum on a valid/ready output for host-side Montgomery conversion.

## Interface
Parameters:
- `DataBits`, default `msu_pkg::TotalWordBits`: width of each `msu` result vector.
- `ChunkBits`, default 64: adder slice width per cycle.
- `IterBits`, default 64: width of the iteration count.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `cfg_iters_i`  in  IterBits  requested squaring count; sampled on accepted `go_i`.
- `go_i`  in  1  start request.
- `busy_o`  out  1  high in every state except IDLE.
- `msu_start_o`  out  1  to `msu` `start_i`.
- `msu_stop_o`  out  1  to `msu` `stop_i`.
- `msu_valid_i`  in  1  from `msu` `valid_o`.
- `msu_nr_i`  in  DataBits  from `msu` `sq_nr_o`.
- `msu_r_i`  in  DataBits  from `msu` `sq_r_o`.
- `iter_count_o`  out  IterBits  completed squarings in the current job.
- `res_o`  out  DataBits+1  nr + r; bit DataBits is the final carry.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  consumer accepts the result.

## Operation
- `NumChunks` = ceil(DataBits/ChunkBits). Both operands are zero-extended to NumChunks*ChunkBits.
- States and transitions:
  - IDLE -> LAUNCH on `go_i` when `cfg_iters_i` != 0. A `go_i` with `cfg_iters_i` == 0 is ignored.
  - LAUNCH -> RUN after one cycle.
  - RUN -> ADD on the capture event.
  - ADD -> OUT after NumChunks cycles.
  - OUT -> IDLE on `res_valid_o && res_ready_i`.
- On accept: latch `cfg_iters_i` and clear `iter_count_o`.
- LAUNCH: `msu_start_o` = 1 for exactly one cycle.
- RUN: each cycle with `msu_valid_i` increments `iter_count_o`.
  - Capture event: `msu_valid_i` high while `iter_count_o` + 1 == the latched count.
  - On capture, register `msu_nr_i` and `msu_r_i`, and assert `msu_stop_o` for exactly the next cycle.
- ADD: chunk k (LSB first) sums nr chunk, r chunk and carry-in. The carry register clears on entry to ADD. After the last chunk, the final carry is written to `res_o[DataBits]`.
- OUT:
  - `res_o` and `res_valid_o` are held stable until the handshake.
  - `go_i` is ignored while `busy_o` is high.
  - `msu_valid_i` is ignored outside RUN.
- `iter_count_o` saturates at the latched count. It is not cleared until the next accepted `go_i`.

## Timing
- Reset values (all outputs): state IDLE, `busy_o` 0, `msu_start_o` 0, `msu_stop_o` 0, `iter_count_o` 0, `res_o` 0, `res_valid_o` 0. The operand registers and carry register are also cleared.
- `go_i` at edge E: LAUNCH in cycle E+1 (`msu_start_o` high), RUN from E+2.
- Capture at edge C: `msu_stop_o` high in cycle C+1; `res_valid_o` high NumChunks cycles after C.
- All outputs are registered. There is no combinational path from `res_ready_i` to any output.
- `rst_i` mid-job returns to IDLE on the next edge with every output at its reset value. `msu` is not sent `stop`; the owner of `msu` resets it on the same reset.
- Simultaneous `res_ready_i` and `go_i` in OUT: the handshake completes and `go_i` is dropped. `go_i` is accepted only in IDLE.

## Configuration
- `MSU_COLLECT_CYCLE_COUNT_EN` defined:
  - Adds output `cycle_count_o` (64 bits). It counts clock cycles from LAUNCH up to and including the capture cycle.
  - It is frozen thereafter, cleared on accepted `go_i` and reset to 0.
- Undefined: the port and counter are absent, with no other behavioural change.

## Structure
- `msu_pkg` holds the state enum typedef, a `NumChunks` function/constant, and the chunk-width type.
- One sub-module, `chunk_adder`: registered ChunkBits-wide add with carry in/out.
- The FSM, counters and operand shift registers live in the top module.

## Test plan
- DataBits 1024, ChunkBits 64: go with `cfg_iters_i` = 3 and a model emitting `msu_valid_i` every 2 cycles -> one `msu_start_o` pulse, `msu_stop_o` exactly one cycle after the 3rd valid, `iter_count_o` = 3.
- nr = all-ones, r = 1 -> `res_o` = 2^1024 (bit 1024 set, rest 0), `res_valid_o` 16 cycles after capture.
- Random nr/r, `res_ready_i` held low 10 cycles -> `res_o` stable and equal to nr+r throughout; IDLE one cycle after ready.
- `go_i` with `cfg_iters_i` = 0, and `go_i` pulses during RUN -> no `msu_start_o`, the job is unaffected.
- `rst_i` asserted during ADD -> next cycle all outputs 0 and IDLE; a fresh go then completes correctly.
- With `MSU_COLLECT_CYCLE_COUNT_EN`, valid every 4 cycles, 5 iterations -> `cycle_count_o` matches the model count and holds after capture.
